// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU sequencer.
// Holds the ALU function codes driven on alu_func and the instruction
// opcodes. It also holds the sequencer state encoding and a helper that
// zero-extends the 8-bit immediate field.
package alu_pkg;

  // ALU function codes
  localparam logic [2:0] FUNC_PASS_B = 3'b000;
  localparam logic [2:0] FUNC_ADD    = 3'b001;
  localparam logic [2:0] FUNC_SUB    = 3'b010;
  localparam logic [2:0] FUNC_AND    = 3'b011;
  localparam logic [2:0] FUNC_OR     = 3'b100;
  localparam logic [2:0] FUNC_SHL    = 3'b101;
  localparam logic [2:0] FUNC_SHR    = 3'b110;

  // Instruction opcodes (instr[15:12])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  function automatic logic [15:0] zext_imm8(input logic [7:0] imm8);
    return {8'h00, imm8};
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder for alu_seq_ctrl.
// Ports:
//   opcode   in  4  instruction opcode field
//   alu_func out 3  ALU function code for ALU-class opcodes (pass-B otherwise)
//   imm_sel  out 1  B operand comes from the immediate (LDI only)
//   uses_alu out 1  opcode goes through EXEC/WAIT/WB
//   is_jmp   out 1  unconditional jump
//   is_jz    out 1  jump if zero flag set
//   is_halt  out 1  halt instruction
// Undefined opcodes decode to all-zero, which the sequencer treats as NOP.
module alu_seq_decode
  import alu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_func,
  output logic       imm_sel,
  output logic       uses_alu,
  output logic       is_jmp,
  output logic       is_jz,
  output logic       is_halt
);

  // Opcode to control-field lookup
  always_comb begin
    alu_func = FUNC_PASS_B;
    imm_sel  = 1'b0;
    uses_alu = 1'b0;
    is_jmp   = 1'b0;
    is_jz    = 1'b0;
    is_halt  = 1'b0;
    case (opcode)
      OP_NOP:  begin end
      OP_LDI:  begin alu_func = FUNC_PASS_B; imm_sel = 1'b1; uses_alu = 1'b1; end
      OP_ADD:  begin alu_func = FUNC_ADD; uses_alu = 1'b1; end
      OP_SUB:  begin alu_func = FUNC_SUB; uses_alu = 1'b1; end
      OP_AND:  begin alu_func = FUNC_AND; uses_alu = 1'b1; end
      OP_OR:   begin alu_func = FUNC_OR;  uses_alu = 1'b1; end
      OP_SHL:  begin alu_func = FUNC_SHL; uses_alu = 1'b1; end
      OP_SHR:  begin alu_func = FUNC_SHR; uses_alu = 1'b1; end
      OP_JMP:  is_jmp  = 1'b1;
      OP_JZ:   is_jz   = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: begin end
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multicycle sequencer for the 16-bit ALU datapath.
// The sequencer fetches an instruction over a request/valid handshake and
// decodes it. ALU instructions then get a one-cycle alu_en, a bounded wait
// for alu_done and a one-cycle write-back strobe. The sequencer keeps its
// own zero flag, which is updated by SUB and tested by JZ.
// Ports:
//   clk, rst                synchronous active-high reset
//   start                   leave IDLE and fetch from pc=0
//   instr_req/addr/valid/data  instruction fetch handshake
//   rf_ra, rf_rb            register-file read addresses (rs, rt)
//   imm_sel, imm_out        immediate B operand select and value
//   alu_en, alu_func        one-cycle ALU enable and function code
//   alu_done, alu_result    ALU completion strobe and result
//   wb_en, wb_addr          one-cycle write-back strobe and target (rd)
//   zf, busy, halted, err   status
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            instr_req,
  output logic [PC_W-1:0] instr_addr,
  input  logic            instr_valid,
  input  logic [15:0]     instr_data,
  output logic [3:0]      rf_ra,
  output logic [3:0]      rf_rb,
  output logic            imm_sel,
  output logic [15:0]     imm_out,
  output logic            alu_en,
  output logic [2:0]      alu_func,
  input  logic            alu_done,
  input  logic [15:0]     alu_result,
  output logic            wb_en,
  output logic [3:0]      wb_addr,
  output logic            zf,
  output logic            busy,
  output logic            halted,
  output logic            err
);

  localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  // Last WAIT count value; reaching it without alu_done ends in ERR
  localparam logic [3:0]      CNT_END = 4'(TIMEOUT - 1);

  state_t          state_r;
  state_t          state_nxt;
  logic [PC_W-1:0] pc_r;
  logic [15:0]     ir_r;
  logic            zf_r;
  logic [3:0]      cnt_r;

  logic [2:0] dec_func;
  logic       dec_imm_sel;
  logic       dec_uses_alu;
  logic       dec_is_jmp;
  logic       dec_is_jz;
  logic       dec_is_halt;

  // The decoder always looks at the latched instruction, so its outputs stay
  // stable from DECODE through WB without extra holding registers.
  alu_seq_decode u_decode (
    .opcode   (ir_r[15:12]),
    .alu_func (dec_func),
    .imm_sel  (dec_imm_sel),
    .uses_alu (dec_uses_alu),
    .is_jmp   (dec_is_jmp),
    .is_jz    (dec_is_jz),
    .is_halt  (dec_is_halt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
        else       state_nxt = ST_IDLE;
      end
      ST_FETCH: begin
        if (instr_valid) state_nxt = ST_DECODE;
        else             state_nxt = ST_FETCH;
      end
      ST_DECODE: begin
        if (dec_is_halt)       state_nxt = ST_HALT;
        else if (dec_uses_alu) state_nxt = ST_EXEC;
        else                   state_nxt = ST_FETCH;
      end
      ST_EXEC: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A completion in the last allowed cycle still wins over timeout
        if (alu_done)               state_nxt = ST_WB;
        else if (cnt_r == CNT_END)  state_nxt = ST_ERR;
        else                        state_nxt = ST_WAIT;
      end
      ST_WB:   state_nxt = ST_FETCH;
      ST_HALT: state_nxt = ST_HALT;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: pc, instruction register, zero flag, wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r  <= '0;
      ir_r  <= 16'h0000;
      zf_r  <= 1'b0;
      cnt_r <= 4'd0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (instr_valid) ir_r <= instr_data;
        end
        ST_DECODE: begin
          if (dec_is_jmp || (dec_is_jz && zf_r)) begin
            pc_r <= PC_W'(ir_r[7:0]);
          end else if (!dec_uses_alu && !dec_is_halt) begin
            // NOP, untaken JZ and undefined opcodes fall through
            pc_r <= pc_r + PC_ONE;
          end
        end
        ST_EXEC: cnt_r <= 4'd0;
        ST_WAIT: begin
          if (alu_done) begin
            if (ir_r[15:12] == OP_SUB) zf_r <= (alu_result == 16'h0000);
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_WB:   pc_r <= pc_r + PC_ONE;
        default: begin end
      endcase
    end
  end

  // Output decode from the current state
  always_comb begin
    instr_req  = 1'b0;
    instr_addr = pc_r;
    rf_ra      = 4'h0;
    rf_rb      = 4'h0;
    imm_sel    = 1'b0;
    imm_out    = 16'h0000;
    alu_en     = 1'b0;
    alu_func   = FUNC_PASS_B;
    wb_en      = 1'b0;
    wb_addr    = 4'h0;
    zf         = zf_r;
    busy       = 1'b0;
    halted     = 1'b0;
    err        = 1'b0;
    case (state_r)
      ST_FETCH: begin
        instr_req = 1'b1;
        busy      = 1'b1;
      end
      ST_DECODE, ST_EXEC, ST_WAIT, ST_WB: begin
        busy     = 1'b1;
        rf_ra    = ir_r[7:4];
        rf_rb    = ir_r[3:0];
        imm_sel  = dec_imm_sel;
        imm_out  = zext_imm8(ir_r[7:0]);
        alu_func = dec_func;
        wb_addr  = ir_r[11:8];
        alu_en   = (state_r == ST_EXEC);
        wb_en    = (state_r == ST_WB);
      end
      ST_HALT: halted = 1'b1;
      ST_ERR:  err    = 1'b1;
      default: begin end
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, instr_req, instr_valid;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data, imm_out, alu_result;
  logic [3:0]  rf_ra, rf_rb, wb_addr;
  logic        imm_sel, alu_en, alu_done, wb_en, zf, busy, halted, err;
  logic [2:0]  alu_func;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.PC_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .imm_sel(imm_sel), .imm_out(imm_out),
    .alu_en(alu_en), .alu_func(alu_func), .alu_done(alu_done),
    .alu_result(alu_result), .wb_en(wb_en), .wb_addr(wb_addr),
    .zf(zf), .busy(busy), .halted(halted), .err(err)
  );

  typedef struct packed {
    logic       alu;
    logic [2:0] func;
    logic       imm_sel;
    logic       halt;
    logic       zf;
    logic [7:0] pc;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] res;
    int          dly;
    exp_t        e;
  } vec_t;

  vec_t tab[18];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [15:0] i, input logic [15:0] r, input int d,
                              input logic a, input logic [2:0] f, input logic s,
                              input logic h, input logic z, input logic [7:0] p);
    vec_t v;
    v.instr = i; v.res = r; v.dly = d;
    v.e.alu = a; v.e.func = f; v.e.imm_sel = s; v.e.halt = h; v.e.zf = z; v.e.pc = p;
    return v;
  endfunction

  // Instruction-level reference: what one instruction does to pc and zf
  function automatic exp_t ref_model(input logic [15:0] instr, input logic [15:0] res,
                                     input logic [7:0] pc, input logic zf_in);
    exp_t e;
    int   op;
    op        = int'(instr[15:12]);
    e.alu     = (op >= 1 && op <= 7);
    e.func    = e.alu ? 3'(op - 1) : 3'b000;
    e.imm_sel = (op == 1);
    e.halt    = (op == 15);
    e.zf      = zf_in;
    e.pc      = pc + 8'd1;
    if (op == 3) e.zf = (res == 16'h0000);
    if (op == 8 || (op == 9 && zf_in)) e.pc = instr[7:0];
    if (op == 15) e.pc = pc;
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; instr_valid = 1'b0; alu_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for a fetch request, check the address, hand over instr
  task automatic fetch_only(input logic [15:0] instr, input int fdly, input logic [7:0] cur_pc);
    int n;
    n = 0;
    while (instr_req !== 1'b1 && n < 20) begin tick(); n++; end
    chk("fetch_req", 32'(instr_req), 32'd1);
    for (int k = 0; k < fdly; k++) begin
      tick();
      chk("req_held", 32'(instr_req), 32'd1);
    end
    chk("instr_addr", 32'(instr_addr), 32'(cur_pc));
    instr_valid = 1'b1; instr_data = instr;
    tick();
    instr_valid = 1'b0; instr_data = 16'($urandom());
  endtask

  task automatic run_instr(input logic [15:0] instr, input logic [15:0] res, input int dly,
                           input int fdly, input logic [7:0] cur_pc, input exp_t e);
    fetch_only(instr, fdly, cur_pc);
    // DECODE
    chk("dec_busy", 32'(busy), 32'd1);
    chk("dec_alu_en", 32'(alu_en), 32'd0);
    chk("dec_wb_en", 32'(wb_en), 32'd0);
    if (e.alu) begin
      chk("rf_ra", 32'(rf_ra), 32'(instr[7:4]));
      chk("rf_rb", 32'(rf_rb), 32'(instr[3:0]));
      chk("dec_func", 32'(alu_func), 32'(e.func));
      chk("imm_sel", 32'(imm_sel), 32'(e.imm_sel));
      chk("imm_out", 32'(imm_out), {24'h0, instr[7:0]});
      chk("dec_wb_addr", 32'(wb_addr), 32'(instr[11:8]));
      // stray completion outside WAIT must be ignored
      alu_done = 1'b1; alu_result = 16'h0000;
      tick();
      // EXEC
      chk("exec_alu_en", 32'(alu_en), 32'd1);
      chk("exec_func", 32'(alu_func), 32'(e.func));
      chk("exec_wb_en", 32'(wb_en), 32'd0);
      tick();
      // WAIT
      alu_done = 1'b0;
      for (int d = 0; d < dly; d++) begin
        chk("wait_alu_en", 32'(alu_en), 32'd0);
        chk("wait_wb_en", 32'(wb_en), 32'd0);
        tick();
      end
      chk("wait_err", 32'(err), 32'd0);
      alu_done = 1'b1; alu_result = res;
      tick();
      // WB
      alu_done = 1'b0; alu_result = 16'($urandom());
      chk("wb_en", 32'(wb_en), 32'd1);
      chk("wb_addr", 32'(wb_addr), 32'(instr[11:8]));
      chk("wb_func_hold", 32'(alu_func), 32'(e.func));
      chk("wb_ra_hold", 32'(rf_ra), 32'(instr[7:4]));
      chk("wb_imm_hold", 32'(imm_sel), 32'(e.imm_sel));
      chk("wb_zf", 32'(zf), 32'(e.zf));
      tick();
      chk("post_wb_en", 32'(wb_en), 32'd0);
      chk("next_pc", 32'(instr_addr), 32'(e.pc));
    end else begin
      tick();
      if (e.halt) begin
        chk("halted", 32'(halted), 32'd1);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_req", 32'(instr_req), 32'd0);
      end else begin
        chk("br_req", 32'(instr_req), 32'd1);
        chk("br_pc", 32'(instr_addr), 32'(e.pc));
        chk("br_zf", 32'(zf), 32'(e.zf));
      end
    end
  endtask

  initial begin
    logic [7:0]  m_pc;
    logic        m_zf;
    logic [15:0] ri, rr;
    logic [11:0] low;
    exp_t        e;

    tab[0]  = mk(16'h2312, 16'h1234, 0,  1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 8'h01);
    tab[1]  = mk(16'h15A7, 16'h00A7, 0,  1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 8'h02);
    tab[2]  = mk(16'h3456, 16'h0000, 1,  1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 8'h03);
    tab[3]  = mk(16'h9040, 16'h0000, 0,  1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 8'h40);
    tab[4]  = mk(16'h4123, 16'h0000, 2,  1'b1, 3'b011, 1'b0, 1'b0, 1'b1, 8'h41);
    tab[5]  = mk(16'h3111, 16'h0001, 0,  1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 8'h42);
    tab[6]  = mk(16'h9040, 16'h0000, 0,  1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h43);
    tab[7]  = mk(16'h5ABC, 16'hFFFF, 3,  1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 8'h44);
    tab[8]  = mk(16'h6111, 16'h0002, 0,  1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 8'h45);
    tab[9]  = mk(16'h7222, 16'h0000, 14, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 8'h46);
    tab[10] = mk(16'h0000, 16'h0000, 0,  1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h47);
    tab[11] = mk(16'hBFFF, 16'h0000, 0,  1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h48);
    tab[12] = mk(16'h80FE, 16'h0000, 0,  1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'hFE);
    tab[13] = mk(16'h2000, 16'h0005, 0,  1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 8'hFF);
    tab[14] = mk(16'h0000, 16'h0000, 0,  1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00);
    tab[15] = mk(16'h3000, 16'h0000, 0,  1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 8'h01);
    tab[16] = mk(16'h8010, 16'h0000, 0,  1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 8'h10);
    tab[17] = mk(16'hF000, 16'h0000, 0,  1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 8'h10);

    rst = 1'b1; start = 1'b0; instr_valid = 1'b0; instr_data = 16'h0000;
    alu_done = 1'b0; alu_result = 16'h0000;

    // Reset state
    do_reset();
    chk("rst_req", 32'(instr_req), 32'd0);
    chk("rst_addr", 32'(instr_addr), 32'd0);
    chk("rst_ra", 32'(rf_ra), 32'd0);
    chk("rst_rb", 32'(rf_rb), 32'd0);
    chk("rst_imm_sel", 32'(imm_sel), 32'd0);
    chk("rst_imm_out", 32'(imm_out), 32'd0);
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_func", 32'(alu_func), 32'd0);
    chk("rst_wb", 32'(wb_en), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_flags", {28'h0, zf, busy, halted, err}, 32'd0);
    tick(); tick();
    chk("idle_no_start", 32'(busy), 32'd0);

    // Directed program from the table, ending in HALT
    do_start();
    m_pc = 8'h00;
    for (int i = 0; i < 18; i++) begin
      run_instr(tab[i].instr, tab[i].res, tab[i].dly, i % 3, m_pc, tab[i].e);
      m_pc = tab[i].e.pc;
    end
    for (int k = 0; k < 4; k++) begin
      start = k[0]; instr_valid = ~k[0];
      tick();
      chk("halt_sticky", 32'(halted), 32'd1);
      chk("halt_no_req", 32'(instr_req), 32'd0);
      chk("halt_not_busy", 32'(busy), 32'd0);
    end
    start = 1'b0; instr_valid = 1'b0;

    // ALU timeout: 15 WAIT cycles, then ERR
    do_reset();
    chk("rst_from_halt", 32'(halted), 32'd0);
    do_start();
    fetch_only(16'h2312, 0, 8'h00);
    tick();
    chk("to_exec", 32'(alu_en), 32'd1);
    for (int w = 1; w <= 15; w++) begin
      tick();
      chk("to_wait_err", 32'(err), 32'd0);
      chk("to_wait_wb", 32'(wb_en), 32'd0);
    end
    tick();
    chk("to_err", 32'(err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("err_sticky", 32'(err), 32'd1);
      chk("err_no_req", 32'(instr_req), 32'd0);
      chk("err_no_wb", 32'(wb_en), 32'd0);
    end
    start = 1'b0;
    do_reset();
    chk("err_cleared", 32'(err), 32'd0);
    chk("err_rst_busy", 32'(busy), 32'd0);

    // rst in the 2nd WAIT cycle, with alu_done on the same edge
    do_start();
    run_instr(16'h3000, 16'h0000, 0, 0, 8'h00, ref_model(16'h3000, 16'h0000, 8'h00, 1'b0));
    fetch_only(16'h2312, 0, 8'h01);
    tick(); tick(); tick();
    rst = 1'b1; alu_done = 1'b1; alu_result = 16'h1111;
    tick();
    rst = 1'b0; alu_done = 1'b0;
    chk("mid_rst_wb", 32'(wb_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pc", 32'(instr_addr), 32'd0);
    chk("mid_rst_zf", 32'(zf), 32'd0);
    tick();
    chk("mid_rst_wb2", 32'(wb_en), 32'd0);

    // Random programs against the instruction-level model
    do_reset();
    do_start();
    m_pc = 8'h00; m_zf = 1'b0;
    for (int i = 0; i < 120; i++) begin
      low = 12'($urandom());
      ri  = {4'($urandom_range(0, 14)), low};
      rr  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom());
      e   = ref_model(ri, rr, m_pc, m_zf);
      run_instr(ri, rr, $urandom_range(0, 6), $urandom_range(0, 2), m_pc, e);
      m_pc = e.pc; m_zf = e.zf;
    end
    e = ref_model(16'hF000, 16'h0000, m_pc, m_zf);
    run_instr(16'hF000, 16'h0000, 0, 0, m_pc, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
